// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S playback path.
package audio_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int SAMPLE_N = 16;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} tx_state_t;

  typedef struct packed {
    logic signed [SAMPLE_N-1:0] left;
    logic signed [SAMPLE_N-1:0] right;
  } sample_pair_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo sample pairs with registered occupancy level.
module sample_fifo
  import audio_pkg::*;
#(
  parameter type pair_t = sample_pair_t,
  parameter int  DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  pair_t                   din,
  output pair_t                   dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/i2s_dac_tx.sv
// Left-justified stereo transmitter to the WM8731 DAC, slaved to codec BCLK/DACLRCK.
// Optional I2S_DAC_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int N                = 16,
  parameter int FIFO_DEPTH       = 4,
  parameter int ZERO_ON_UNDERRUN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [N-1:0]          s_left,
  input  logic signed [N-1:0]          s_right,
  input  logic                         bclk,
  input  logic                         daclrck,
  output logic                         dacdat,
  output logic                         frame_start,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_count
`endif
);
  typedef struct packed {
    logic signed [N-1:0] left;
    logic signed [N-1:0] right;
  } pair_t;

  localparam logic [5:0] WORD_BITS = 6'(N);

  pair_t                fifo_din;
  pair_t                fifo_dout;
  pair_t                hold;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  tx_state_t            state;
  logic [N-1:0]         shreg;
  logic [N-1:0]         shifted;
  logic [N-1:0]         left_word;
  logic [5:0]           bitcnt;
  logic [SYNC_STAGES:0] bclk_sync;
  logic [SYNC_STAGES:0] lrck_sync;
  logic                 lrck_rise;
  logic                 lrck_fall;
  logic                 bclk_fall;

  // Sync stages 0..SYNC_STAGES-1, then one history flop for edge detection
  always_ff @(posedge clk) begin
    bclk_sync <= {bclk_sync[SYNC_STAGES-1:0], bclk};
    lrck_sync <= {lrck_sync[SYNC_STAGES-1:0], daclrck};
  end

  assign lrck_rise = lrck_sync[SYNC_STAGES-1] && !lrck_sync[SYNC_STAGES];
  assign lrck_fall = !lrck_sync[SYNC_STAGES-1] && lrck_sync[SYNC_STAGES];
  assign bclk_fall = !bclk_sync[SYNC_STAGES-1] && bclk_sync[SYNC_STAGES];

  assign pop         = lrck_rise && !fifo_empty;
  assign frame_start = lrck_rise && !rst;
  assign underrun    = lrck_rise && fifo_empty && !rst;
  assign s_ready     = !fifo_full;
  assign fifo_din    = {s_left, s_right};
  assign shifted     = shreg << 1;

  sample_fifo #(
    .pair_t (pair_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    left_word = hold.left;
    if (!fifo_empty)                left_word = fifo_dout.left;
    else if (ZERO_ON_UNDERRUN != 0) left_word = '0;
  end

  // LRCK edges take priority over a coincident BCLK fall so the MSB is never skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dacdat <= 1'b0;
      hold   <= '0;
      shreg  <= '0;
      bitcnt <= '0;
    end else if (lrck_rise) begin
      state <= LEFT;
      if (!fifo_empty)                hold <= fifo_dout;
      else if (ZERO_ON_UNDERRUN != 0) hold <= '0;
      shreg  <= left_word;
      dacdat <= left_word[N-1];
      bitcnt <= WORD_BITS;
    end else if (lrck_fall && state == LEFT) begin
      state  <= RIGHT;
      shreg  <= hold.right;
      dacdat <= hold.right[N-1];
      bitcnt <= WORD_BITS;
    end else if (bclk_fall && state != IDLE) begin
      if (bitcnt > 6'd1) begin
        shreg  <= shifted;
        dacdat <= shifted[N-1];
        bitcnt <= bitcnt - 1'b1;
      end else begin
        dacdat <= 1'b0;
        bitcnt <= '0;
      end
    end
  end

`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (underrun && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: one zero-on-underrun and one repeat-on-underrun instance.
module tb_i2s_dac_tx;
  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [N-1:0] s_left;
  logic [N-1:0] s_right;
  logic        bclk;
  logic        daclrck;
  logic        s_ready, dacdat, frame_start, underrun;
  logic [2:0]  fifo_level;
  logic        s_ready2, dacdat2, frame_start2, underrun2;
  logic [2:0]  fifo_level2;

  int compared   = 0;
  int mismatched = 0;
  int fs_cnt     = 0;
  int ur_cnt     = 0;
  logic [31:0] lb, rb, lb2, rb2;

  logic [15:0] lv [7] = '{16'h8001, 16'hC35A, 16'h9BDF, 16'hF00F, 16'h6666, 16'hFFFF, 16'h4321};
  logic [15:0] rv [7] = '{16'h7FFE, 16'h3CA5, 16'h1357, 16'h0FF0, 16'h9999, 16'h0001, 16'hBEEF};

  always #5 clk = ~clk;

  i2s_dac_tx #(.N(N), .FIFO_DEPTH(DEPTH), .ZERO_ON_UNDERRUN(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .bclk(bclk), .daclrck(daclrck),
    .dacdat(dacdat), .frame_start(frame_start), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  i2s_dac_tx #(.N(N), .FIFO_DEPTH(DEPTH), .ZERO_ON_UNDERRUN(0)) dut_rep (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2),
    .s_left(s_left), .s_right(s_right), .bclk(bclk), .daclrck(daclrck),
    .dacdat(dacdat2), .frame_start(frame_start2), .underrun(underrun2),
    .fifo_level(fifo_level2)
  );

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (underrun)    ur_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h, required %08h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // BCLK = clk/16; LRCK toggles on a BCLK fall; dacdat sampled at each BCLK rise.
  task automatic send_frame(input int bpp);
    lb = '0; rb = '0; lb2 = '0; rb2 = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int b = 0; b < bpp; b++) begin
        @(negedge clk);
        bclk = 1'b0;
        if (b == 0) daclrck = (ph == 0);
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        if (ph == 0) begin
          lb  = {lb[30:0], dacdat};
          lb2 = {lb2[30:0], dacdat2};
        end else begin
          rb  = {rb[30:0], dacdat};
          rb2 = {rb2[30:0], dacdat2};
        end
        repeat (7) @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
    bclk = 1'b1; daclrck = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dacdat", 32'(dacdat), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;

    push_pair(16'hA5C3, 16'h0F0F);
    check("push1_level", 32'(fifo_level), 32'd1);
    send_frame(32);
    check("f1_left", lb, 32'hA5C3_0000);
    check("f1_right", rb, 32'h0F0F_0000);
    check("f1_fs_cnt", 32'(fs_cnt), 32'd1);
    check("f1_ur_cnt", 32'(ur_cnt), 32'd0);
    check("f1_level", 32'(fifo_level), 32'd0);

    send_frame(32);
    check("f2_left_zero", lb, 32'h0);
    check("f2_right_zero", rb, 32'h0);
    check("f2_ur_cnt", 32'(ur_cnt), 32'd1);
    check("f2_rep_left", lb2, 32'hA5C3_0000);
    check("f2_rep_right", rb2, 32'h0F0F_0000);

    @(negedge clk);
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_left = lv[i]; s_right = rv[i];
      @(negedge clk);
    end
    s_left = lv[4]; s_right = rv[4];
    @(negedge clk);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);

    fork
      send_frame(32);
      begin
        int k;
        k = 0;
        while (s_ready !== 1'b1 && k < 200) begin
          @(negedge clk);
          k++;
        end
        check("ready_after_pop", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
      end
    join
    check("f3_left", lb, 32'h8001_0000);
    check("f3_right", rb, 32'h7FFE_0000);
    check("f3_level", 32'(fifo_level), 32'd4);

    send_frame(8);
    check("short1_left", {24'h0, lb[7:0]}, 32'hC3);
    check("short1_right", {24'h0, rb[7:0]}, 32'h3C);
    send_frame(8);
    check("short2_left", {24'h0, lb[7:0]}, 32'h9B);
    check("short2_right", {24'h0, rb[7:0]}, 32'h13);
    check("short2_level", 32'(fifo_level), 32'd2);

    fork
      send_frame(32);
      begin
        repeat (3) @(negedge clk);
        s_valid = 1'b1; s_left = lv[5]; s_right = rv[5];
        @(negedge clk);
        s_valid = 1'b0;
        check("pushpop_level", 32'(fifo_level), 32'd2);
      end
    join
    check("f6_left", lb, 32'hF00F_0000);
    check("f6_right", rb, 32'h0FF0_0000);

    send_frame(32);
    check("f7_left", lb, 32'h6666_0000);
    check("f7_right", rb, 32'h9999_0000);
    check("f7_level", 32'(fifo_level), 32'd1);

    fork
      send_frame(32);
      begin
        repeat (100) @(negedge clk);
        check("pre_rst_bit", 32'(dacdat), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dacdat", 32'(dacdat), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        push_pair(lv[6], rv[6]);
      end
    join
    check("f8_right_idle", rb, 32'h0);
    check("f8_rep_right_idle", rb2, 32'h0);
    check("f8_level", 32'(fifo_level), 32'd1);

    send_frame(32);
    check("f9_left", lb, 32'h4321_0000);
    check("f9_right", rb, 32'hBEEF_0000);
    check("final_fs_cnt", 32'(fs_cnt), 32'd9);
    check("final_ur_cnt", 32'(ur_cnt), 32'd1);
    check("final_level", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Left-justified serial audio transmitter driving the WM8731 DAC input (AUD_DACDAT), the playback counterpart of the microphone capture path. The codec is bus master: it supplies BCLK and DACLRCK, which this block oversamples on the fast system clock. Stereo sample pairs arrive over a valid/ready stream, are buffered in a small FIFO, and are shifted out MSB-first, one channel per LRCK phase.

## Interface
Parameters:
- N, 16: sample width in bits; must be ≤ 32 and ≤ BCLKs per LRCK half-period.
- FIFO_DEPTH, 4: sample-pair FIFO depth; power of two, ≥ 2.
- ZERO_ON_UNDERRUN, 1: 1 sends zeros on underrun; 0 repeats the last pair.

Ports:
- clk  in  1  system clock (CLOCK_50); must be ≥ 8× BCLK frequency.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  FIFO can accept; equals !full.
- s_left  in  N  left sample, two's complement.
- s_right  in  N  right sample, two's complement.
- bclk  in  1  codec bit clock (AUD_BCLK), asynchronous to clk.
- daclrck  in  1  codec DAC LR clock (AUD_DACLRCK), high = left; asynchronous.
- dacdat  out  1  serial data to codec (AUD_DACDAT), registered.
- frame_start  out  1  one-clk pulse when a left word is loaded.
- underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- bclk and daclrck each pass through a 2-FF synchronizer plus one history FF. Edges are detected on the synchronized signals: lrck_rise, lrck_fall, bclk_fall.
- FSM states:
  - IDLE: reset state; dacdat = 0. lrck_rise moves to LEFT. An lrck_fall in IDLE is ignored.
  - LEFT: lrck_fall moves to RIGHT.
  - RIGHT: lrck_rise moves to LEFT.
- On lrck_rise:
  - FIFO non-empty: pop one pair into the hold registers.
  - FIFO empty: pulse underrun. Hold registers become 0 if ZERO_ON_UNDERRUN = 1; otherwise they keep the previous pair.
  - Load the shift register with the left word, drive its MSB, set bitcnt = N, pulse frame_start.
- On lrck_fall in LEFT: load the shift register with the held right word, drive its MSB, set bitcnt = N.
- On bclk_fall in LEFT or RIGHT:
  - bitcnt > 1: shift left, drive the next bit, decrement bitcnt.
  - bitcnt = 1: drive 0, set bitcnt = 0.
  - bitcnt = 0: hold 0.
- Same-cycle lrck edge and bclk_fall: the lrck edge wins. Load the MSB; do not shift.
- An LRCK edge arriving before N bits are sent truncates the word. The new word loads normally.
- FIFO push on s_valid && s_ready.
  - Push and pop in the same cycle: both occur, level unchanged.
  - Push while full: ignored, since s_ready = 0.
- Reset values (including reset mid-frame): dacdat = 0, s_ready = 1, frame_start = 0, underrun = 0, fifo_level = 0, hold registers = 0, FIFO flushed, state IDLE. Transmission resumes only at the next lrck_rise.

## Timing
- Raw LRCK edge to dacdat MSB: 3 clk (2 sync + 1 output register). A raw BCLK falling edge to the next bit: 3 clk.
- At clk ≥ 8× BCLK, dacdat is stable ≥ 1 clk before the next BCLK rising edge, where the codec samples.
- s_ready updates the cycle after a push or pop; it is combinational from registered FIFO state.
- fifo_level is registered and reflects pushes and pops from the previous cycle.
- frame_start and underrun assert in the same cycle as the internal lrck_rise detection.

## Configuration
- I2S_DAC_TX_UNDERRUN_CNT_EN defined: adds output underrun_count (16 bits), which increments on each underrun pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Package audio_pkg:
  - tx_state_t enum {IDLE, LEFT, RIGHT};
  - sample_pair_t struct {left, right} parameterized by N via a localparam default of 16;
  - SYNC_STAGES = 2.
- Sub-module sample_fifo: synchronous FIFO of sample_pair_t with depth FIFO_DEPTH, push/pop/full/empty/level. All remaining logic sits in i2s_dac_tx.

## Test plan
- Reset then push pair (16'hA5C3, 16'h0F0F) with BCLK = clk/16 and 32 BCLK per frame → left phase bits 1010010111000011, right phase 0000111100001111, then zeros; frame_start pulses once.
- No push after reset, one frame → underrun pulses once and dacdat stays 0. Repeat with ZERO_ON_UNDERRUN = 0 after one sent pair → that pair is repeated.
- Push 5 pairs back-to-back, FIFO_DEPTH = 4, no frames → s_ready drops after the 4th; the 5th is held until the first lrck_rise; fifo_level reaches 4.
- Push on the exact cycle of a pop with level = 2 → level stays 2 and the data order is preserved.
- LRCK and BCLK falling on the same raw edge → MSB appears at the edge and no bit is skipped. Short frame (8 BCLK per phase, N = 16) → 8 MSBs sent, the next word loads cleanly.
- Assert rst mid left word → dacdat = 0 the next clk and the FIFO is empty. After release, output stays 0 until the next LRCK rise, then the first newly pushed pair is sent.
